// File: rtl/fetch_pkg.sv
// fetch_pkg: shared widths, constants and the buffered fetch entry type.
package fetch_pkg;
  localparam int PC_W = 64;
  localparam int INSTR_W = 32;
  localparam int INSTR_BYTES = 4;
  localparam int IMEM_WORDS = 64;
  typedef struct packed {
    logic [PC_W-1:0]    pc;
    logic [INSTR_W-1:0] instr;
  } fetch_entry_t;
endpackage

// File: rtl/fetch_fifo2.sv
// fetch_fifo2: two-entry FIFO of fetch entries with push, pop and flush.
module fetch_fifo2
  import fetch_pkg::*;
(
  input  logic         clk,
  input  logic         rst,
  input  logic         push_i,
  input  logic         pop_i,
  input  logic         flush_i,
  input  fetch_entry_t din_i,
  output fetch_entry_t head_o,
  output logic [1:0]   count_o
);
  fetch_entry_t e_q [2];
  fetch_entry_t e_d [2];
  logic [1:0] count_q, count_d, wr_idx;
  // Shift on pop, then write the new entry into the first free slot.
  always_comb begin
    wr_idx = count_q - {1'b0, pop_i};
    e_d[0] = (push_i && wr_idx == 2'd0) ? din_i : pop_i ? e_q[1] : e_q[0];
    e_d[1] = (push_i && wr_idx == 2'd1) ? din_i : e_q[1];
    count_d = flush_i ? 2'd0 : count_q + {1'b0, push_i} - {1'b0, pop_i};
  end
  always_ff @(posedge clk) begin
    if (rst) count_q <= 2'd0;
    else count_q <= count_d;
  end
  always_ff @(posedge clk) begin
    e_q <= e_d;
  end
  assign head_o  = e_q[0];
  assign count_o = count_q;
endmodule

// File: rtl/fetch_stage.sv
// fetch_stage: PC register, imem addressing and a 2-entry buffer toward decode
// with redirect flush; outputs come only from buffered state.
module fetch_stage
  import fetch_pkg::*;
#(
  parameter int N  = PC_W,
  parameter int IW = INSTR_W,
  parameter int AW = 6,
  parameter logic [N-1:0] RESET_PC = '0
) (
  input  logic          clk,
  input  logic          reset,
  output logic [AW-1:0] imem_addr,
  input  logic [IW-1:0] imem_q,
  input  logic          redirect,
  input  logic [N-1:0]  redirect_pc,
  output logic          out_valid,
  input  logic          out_ready,
  output logic [IW-1:0] out_instr,
  output logic [N-1:0]  out_pc
);
  localparam logic [N-1:0] ALIGN = ~N'(3);
  logic [N-1:0] pc_q, pc_d;
  logic [1:0] count;
  logic pop, push;
  fetch_entry_t entry, head;
  assign pop   = out_valid & out_ready;
  assign push  = !redirect & (!count[1] | pop);
  assign entry = '{pc: pc_q, instr: imem_q};
  always_comb begin
    pc_d = redirect ? (redirect_pc & ALIGN) : push ? pc_q + N'(INSTR_BYTES) : pc_q;
  end
  always_ff @(posedge clk) begin
    if (reset) pc_q <= RESET_PC & ALIGN;
    else pc_q <= pc_d;
  end
  fetch_fifo2 u_fifo (
    .clk     (clk),
    .rst     (reset),
    .push_i  (push),
    .pop_i   (pop),
    .flush_i (redirect),
    .din_i   (entry),
    .head_o  (head),
    .count_o (count)
  );
  // Reset masks the outputs immediately, even before the buffer clears.
  assign imem_addr = reset ? RESET_PC[AW+1:2] : pc_q[AW+1:2];
  assign out_valid = !reset && count != 2'd0;
  assign out_instr = out_valid ? head.instr : '0;
  assign out_pc    = out_valid ? head.pc : '0;
endmodule

// File: tb/tb_fetch_stage.sv
// tb_fetch_stage: table-driven cycle checks plus a random-handshake scoreboard.
module tb_fetch_stage;
  logic clk = 1'b0;
  logic reset = 1'b1;
  logic redirect = 1'b0;
  logic out_ready = 1'b0;
  logic [63:0] redirect_pc = '0;
  logic [5:0] imem_addr;
  logic [31:0] imem_q, out_instr;
  logic out_valid;
  logic [63:0] out_pc;
  logic [31:0] rom [64];
  int n_checks = 0;
  int n_fail = 0;

  typedef struct {
    logic rst, rdy, rd;
    logic [63:0] rpc;
    logic ev;
    logic [63:0] epc;
    logic [31:0] ei;
    logic [5:0] ea;
  } vec_t;
  vec_t vt[$];
  logic [63:0] exp_q[$];
  logic [63:0] tail, e;
  int pops;

  assign imem_q = rom[imem_addr];
  always #5 clk = ~clk;

  fetch_stage dut (
    .clk         (clk),
    .reset       (reset),
    .imem_addr   (imem_addr),
    .imem_q      (imem_q),
    .redirect    (redirect),
    .redirect_pc (redirect_pc),
    .out_valid   (out_valid),
    .out_ready   (out_ready),
    .out_instr   (out_instr),
    .out_pc      (out_pc)
  );

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic v(input logic rst, input logic rdy, input logic rd, input logic [63:0] rpc,
                   input logic ev, input logic [63:0] epc, input logic [31:0] ei, input logic [5:0] ea);
    vt.push_back('{rst, rdy, rd, rpc, ev, epc, ei, ea});
  endtask

  initial begin
    for (int w = 0; w < 64; w++) rom[w] = {8'hA5, 8'(w), 16'(w * 7 + 1)};
    rom[0]  = 32'hf8000001;
    rom[1]  = 32'hf8008002;
    rom[2]  = 32'hf8000203;
    rom[29] = 32'hb4ffff82;
    rom[63] = 32'h0;
    //  rst rdy rd  rpc     ev  epc       instr         addr
    v(1, 1, 0, 64'h0,   0, 64'h0,   32'h0,       6'd0);
    v(0, 1, 0, 64'h0,   1, 64'h0,   rom[0],      6'd1);
    v(0, 1, 0, 64'h0,   1, 64'h4,   rom[1],      6'd2);
    v(0, 1, 0, 64'h0,   1, 64'h8,   rom[2],      6'd3);
    v(1, 0, 0, 64'h0,   0, 64'h0,   32'h0,       6'd0);
    v(0, 0, 0, 64'h0,   1, 64'h0,   rom[0],      6'd1);
    v(0, 0, 0, 64'h0,   1, 64'h0,   rom[0],      6'd2);
    v(0, 0, 0, 64'h0,   1, 64'h0,   rom[0],      6'd2);
    v(0, 0, 0, 64'h0,   1, 64'h0,   rom[0],      6'd2);
    v(0, 1, 0, 64'h0,   1, 64'h4,   rom[1],      6'd3);
    v(0, 1, 0, 64'h0,   1, 64'h8,   rom[2],      6'd4);
    v(0, 0, 1, 64'h74,  0, 64'h0,   32'h0,       6'd29);
    v(0, 0, 0, 64'h0,   1, 64'h74,  rom[29],     6'd30);
    v(0, 1, 1, 64'h77,  0, 64'h0,   32'h0,       6'd29);
    v(0, 1, 0, 64'h0,   1, 64'h74,  rom[29],     6'd30);
    v(0, 0, 0, 64'h0,   1, 64'h74,  rom[29],     6'd31);
    v(0, 1, 1, 64'h10,  0, 64'h0,   32'h0,       6'd4);
    v(0, 1, 0, 64'h0,   1, 64'h10,  rom[4],      6'd5);
    v(0, 1, 0, 64'h0,   1, 64'h14,  rom[5],      6'd6);
    v(0, 1, 1, 64'h40,  0, 64'h0,   32'h0,       6'd16);
    v(0, 1, 1, 64'hFC,  0, 64'h0,   32'h0,       6'd63);
    v(0, 1, 0, 64'h0,   1, 64'hFC,  32'h0,       6'd0);
    v(0, 1, 0, 64'h0,   1, 64'h100, rom[0],      6'd1);
    v(0, 0, 0, 64'h0,   1, 64'h100, rom[0],      6'd2);
    v(1, 0, 1, 64'h40,  0, 64'h0,   32'h0,       6'd0);
    v(0, 1, 0, 64'h0,   1, 64'h0,   rom[0],      6'd1);
    v(0, 1, 0, 64'h0,   1, 64'h4,   rom[1],      6'd2);
    foreach (vt[i]) begin
      reset = vt[i].rst;
      out_ready = vt[i].rdy;
      redirect = vt[i].rd;
      redirect_pc = vt[i].rpc;
      @(posedge clk);
      #1;
      check($sformatf("row%0d valid", i), 64'(out_valid), 64'(vt[i].ev));
      check($sformatf("row%0d pc", i), out_pc, vt[i].epc);
      check($sformatf("row%0d instr", i), 64'(out_instr), 64'(vt[i].ei));
      check($sformatf("row%0d addr", i), 64'(imem_addr), 64'(vt[i].ea));
    end
    // Random handshakes and redirects against a predicted delivery stream.
    reset = 1'b1;
    redirect = 1'b0;
    @(posedge clk);
    #1;
    reset = 1'b0;
    pops = 0;
    tail = 64'h0;
    exp_q.delete();
    while (exp_q.size() < 4) begin
      exp_q.push_back(tail);
      tail += 64'd4;
    end
    for (int c = 0; c < 400; c++) begin
      out_ready = $urandom_range(0, 3) != 0;
      redirect = $urandom_range(0, 15) == 0;
      redirect_pc = {$urandom, $urandom};
      #1;
      if (out_valid && out_ready) begin
        e = exp_q.pop_front();
        check("sb pc", out_pc, e);
        check("sb instr", 64'(out_instr), 64'(rom[e[7:2]]));
        pops++;
      end else if (!out_valid) begin
        check("sb idle pc", out_pc, 64'h0);
      end
      if (redirect) begin
        exp_q.delete();
        tail = redirect_pc & ~64'h3;
      end
      while (exp_q.size() < 4) begin
        exp_q.push_back(tail);
        tail += 64'd4;
      end
      @(posedge clk);
      #1;
    end
    check("sb throughput", 64'(pops > 100), 64'h1);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
